// File: rtl/output_transform_unit_if.sv
// ============================================================================
// output_transform_unit_if : start / tile / status bundle of the output transform
// Revision : 1.0
// ============================================================================
`default_nettype none

interface output_transform_unit_if;
   logic                     start;
   logic [0:5][0:5][31:0]    tile_in;
   logic [0:3][0:3][31:0]    tile_out;
   logic                     busy;
   logic                     transform_done;

   modport master (
      output start,
      output tile_in,
      input  tile_out,
      input  busy,
      input  transform_done
   );

   modport slave (
      input  start,
      input  tile_in,
      output tile_out,
      output busy,
      output transform_done
   );
endinterface

`default_nettype wire

// File: rtl/output_transform_unit.sv
// ============================================================================
// output_transform_unit : Winograd F(4x4,3x3) output transform Y = At*M*A,
// two registered shift/add passes. Optional macro OUTPUT_TRANSFORM_RELU_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module output_transform_unit (
   input  wire logic               clk,
   input  wire logic               rst_n,
   output_transform_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC_T = 2'd1,
      S_CALC_Y = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                  state_q;
   logic [0:5][0:5][31:0]   mr_q;
   logic [0:3][0:5][31:0]   t_q;
   logic [0:3][0:5][31:0]   t_d;
   logic [0:3][0:3][31:0]   tile_out_q;
   logic [0:3][0:3][31:0]   y_d;
   logic                    busy_q;
   logic                    done_q;

   // One row of At applied to a 6-element vector; all sums wrap mod 2^32.
   function automatic logic [31:0] at_row(
      input logic [1:0]  row,
      input logic [31:0] v0,
      input logic [31:0] v1,
      input logic [31:0] v2,
      input logic [31:0] v3,
      input logic [31:0] v4,
      input logic [31:0] v5
   );
      logic [31:0] r;
      case (row)
         2'd0:    r = v0 + v1 + v2 + v3 + v4;
         2'd1:    r = v1 - v2 + (v3 << 1) - (v4 << 1);
         2'd2:    r = v1 + v2 + (v3 << 2) + (v4 << 2);
         default: r = v1 - v2 + (v3 << 3) - (v4 << 3) + v5;
      endcase
      return r;
   endfunction

   always_comb begin
      t_d = '0;
      y_d = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 6; j++) begin
            t_d[i][j] = at_row(i[1:0], mr_q[0][j], mr_q[1][j], mr_q[2][j],
                               mr_q[3][j], mr_q[4][j], mr_q[5][j]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            y_d[i][j] = at_row(j[1:0], t_q[i][0], t_q[i][1], t_q[i][2],
                               t_q[i][3], t_q[i][4], t_q[i][5]);
`ifdef OUTPUT_TRANSFORM_RELU_EN
            if (y_d[i][j][31]) begin
               y_d[i][j] = '0;
            end
`endif
         end
      end
   end

   // start is only looked at in S_IDLE, so a held start re-arms on every idle visit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mr_q       <= '0;
         t_q        <= '0;
         tile_out_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  mr_q    <= bus.tile_in;
                  busy_q  <= 1'b1;
                  state_q <= S_CALC_T;
               end
            end
            S_CALC_T: begin
               t_q     <= t_d;
               state_q <= S_CALC_Y;
            end
            S_CALC_Y: begin
               tile_out_q <= y_d;
               state_q    <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.tile_out       = tile_out_q;
   assign bus.busy           = busy_q;
   assign bus.transform_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_output_transform_unit.sv
// ============================================================================
// tb_output_transform_unit : table vectors, handshake sequences and random
// tiles checked against a matrix-multiply reference of Y = At*M*A.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_output_transform_unit;

   typedef logic [0:5][0:5][31:0] tile_t;
   typedef logic [0:3][0:3][31:0] y_t;

   typedef struct {
      string name;
      tile_t m;
      y_t    ey;
   } vec_t;

   typedef struct {
      int    e;
      tile_t m;
   } pend_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   output_transform_unit_if bus();

   output_transform_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   int at_m [0:3][0:5] = '{'{1, 1,  1, 1,  1, 0},
                           '{0, 1, -1, 2, -2, 0},
                           '{0, 1,  1, 4,  4, 0},
                           '{0, 1, -1, 8, -8, 1}};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_tile(input string name, input y_t act, input y_t exp);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            check($sformatf("%s_y%0d%0d", name, i, j), act[i][j], exp[i][j]);
   endtask

   function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef OUTPUT_TRANSFORM_RELU_EN
      return x[31] ? 32'd0 : x;
`else
      return x;
`endif
   endfunction

   // Plain integer matrix products; int arithmetic wraps mod 2^32.
   function automatic y_t ref_model(input tile_t m);
      int t [0:3][0:5];
      int acc;
      y_t y;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 6; j++) begin
            acc = 0;
            for (int k = 0; k < 6; k++) acc += at_m[i][k] * int'(m[k][j]);
            t[i][j] = acc;
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = 0;
            for (int k = 0; k < 6; k++) acc += t[i][k] * at_m[j][k];
            y[i][j] = relu(acc);
         end
      return y;
   endfunction

   function automatic y_t outer(input int a [0:3], input int b [0:3], input int s);
      y_t y;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            y[i][j] = relu(a[i] * b[j] * s);
      return y;
   endfunction

   function automatic tile_t rand_tile();
      tile_t m;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            m[i][j] = $urandom;
      return m;
   endfunction

   task automatic run_tile(input tile_t m, output y_t y);
      int lat;
      @(negedge clk);
      bus.tile_in = m;
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.tile_in = rand_tile();
      check("busy_after_start", {31'd0, bus.busy}, 32'd1);
      lat = 0;
      for (int n = 1; n <= 10 && lat == 0; n++) begin
         @(posedge clk);
         #1;
         if (bus.transform_done) lat = n;
      end
      check("done_latency", lat, 32'd3);
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      y = bus.tile_out;
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'd0, bus.transform_done}, 32'd0);
   endtask

   vec_t  vecs [0:5];
   int    s_ones [0:3] = '{5, 0, 10, 1};
   int    c_imp  [0:3] = '{1, 2, 4, 8};
   int    e_last [0:3] = '{0, 0, 0, 1};
   y_t    y;
   tile_t m0;
   int    ndone;
   int    free_at;
   tile_t held [0:15];
   pend_t pq [$];
   logic  exp_done;

   initial begin
      bus.start   = 1'b0;
      bus.tile_in = '0;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.transform_done}, 32'd0);
      check_tile("reset_tile", bus.tile_out, '0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs[0].name = "zero";    vecs[0].m = '0;
      vecs[0].ey   = '0;
      vecs[1].name = "imp55";   vecs[1].m = '0; vecs[1].m[5][5] = 32'd1;
      vecs[1].ey   = outer(e_last, e_last, 1);
      vecs[2].name = "imp33";   vecs[2].m = '0; vecs[2].m[3][3] = 32'd1;
      vecs[2].ey   = outer(c_imp, c_imp, 1);
      vecs[3].name = "neg33";   vecs[3].m = '0; vecs[3].m[3][3] = 32'hFFFF_FFFF;
      vecs[3].ey   = outer(c_imp, c_imp, -1);
      vecs[4].name = "wrap33";  vecs[4].m = '0; vecs[4].m[3][3] = 32'h0400_0000;
      vecs[4].ey   = outer(c_imp, c_imp, 32'h0400_0000);
      vecs[5].name = "ones";
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            vecs[5].m[i][j] = 32'd1;
      vecs[5].ey   = outer(s_ones, s_ones, 1);

      for (int v = 0; v < 6; v++) begin
         run_tile(vecs[v].m, y);
         check_tile(vecs[v].name, y, vecs[v].ey);
      end

      // Reset while in the first compute pass.
      @(negedge clk);
      bus.tile_in = rand_tile();
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_done", {31'd0, bus.transform_done}, 32'd0);
      check_tile("midrst_tile", bus.tile_out, '0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         if (bus.transform_done) ndone++;
      end
      check("midrst_no_done", ndone, 32'd0);

      // Extra start pulses while busy are ignored.
      m0 = rand_tile();
      @(negedge clk);
      bus.tile_in = m0;
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      ndone = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n <= 2) begin
            bus.start   = 1'b1;
            bus.tile_in = rand_tile();
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (bus.transform_done) begin
            ndone++;
            check("ignored_done_edge", n, 32'd3);
         end
      end
      check("ignored_single_done", ndone, 32'd1);
      check_tile("ignored_tile", bus.tile_out, ref_model(m0));

      // start held high: accepted on every idle visit, one done per tile.
      free_at = 0;
      for (int e = 0; e < 16; e++) begin
         @(negedge clk);
         held[e]     = rand_tile();
         bus.tile_in = held[e];
         bus.start   = (e < 12);
         if (e < 12 && e >= free_at) begin
            pq.push_back('{e: e + 3, m: held[e]});
            free_at = e + 4;
         end
         @(posedge clk);
         #1;
         exp_done = (pq.size() > 0) && (pq[0].e == e);
         check($sformatf("held_done_e%0d", e), {31'd0, bus.transform_done}, {31'd0, exp_done});
         if (exp_done) begin
            check_tile($sformatf("held_tile_e%0d", e), bus.tile_out, ref_model(pq[0].m));
            void'(pq.pop_front());
         end
      end
      bus.start = 1'b0;
      repeat (4) @(posedge clk);

      for (int r = 0; r < 20; r++) begin
         m0 = rand_tile();
         if (r < 10) begin
            for (int i = 0; i < 6; i++)
               for (int j = 0; j < 6; j++)
                  m0[i][j] = $urandom_range(0, 255) - 128;
         end
         run_tile(m0, y);
         check_tile($sformatf("rand%0d", r), y, ref_model(m0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
